// File: rtl/blk_col_var_dly_if.sv
// blk_col_var_dly_if: control, column stream and status bundle for the variable delay line
// master: drives ce/flush/dly_load/dly_cfg/blk_col_i/blk_col_ivalid, observes the outputs
// slave : the delay line itself; drives blk_col_o/blk_col_ovalid/cur_dly/pending
interface blk_col_var_dly_if #(
    parameter int DATA_W  = 32,
    parameter int MAX_DLY = 8
);
    localparam int AW = $clog2(MAX_DLY + 1);
    logic              ce;
    logic              flush;
    logic              dly_load;
    logic [AW-1:0]     dly_cfg;
    logic [DATA_W-1:0] blk_col_i;
    logic              blk_col_ivalid;
    logic [DATA_W-1:0] blk_col_o;
    logic              blk_col_ovalid;
    logic [AW-1:0]     cur_dly;
    logic              pending;
    modport master (
        output ce, flush, dly_load, dly_cfg, blk_col_i, blk_col_ivalid,
        input  blk_col_o, blk_col_ovalid, cur_dly, pending
    );
    modport slave (
        input  ce, flush, dly_load, dly_cfg, blk_col_i, blk_col_ivalid,
        output blk_col_o, blk_col_ovalid, cur_dly, pending
    );
endinterface

// File: rtl/blk_col_var_dly.sv
// blk_col_var_dly: runtime-programmable delay line for block columns with stall, flush and drain status
// clk, rst : clock and asynchronous active-high reset
// io_col   : slave side of blk_col_var_dly_if (controls, column in/out, cur_dly, pending)
module blk_col_var_dly #(
    parameter int DATA_W  = 32,
    parameter int MAX_DLY = 8,
    parameter int DEF_DLY = 1
) (
    input logic             clk,
    input logic             rst,
    blk_col_var_dly_if.slave io_col
);
    localparam int AW = $clog2(MAX_DLY + 1);
    logic [DATA_W-1:0] r_data [MAX_DLY];
    logic [MAX_DLY-1:0] r_vld;
    logic [AW-1:0]      r_cur_dly;
    logic [MAX_DLY:0]   w_vld_ext;
    logic [AW-1:0]      w_dly_clamp;
    logic [DATA_W-1:0]  w_col_o;
    logic               w_vld_o;
    logic               w_pending;
    assign w_vld_ext   = {r_vld, io_col.blk_col_ivalid};
    assign w_dly_clamp = io_col.dly_cfg == '0 ? AW'(1) :
                         io_col.dly_cfg > AW'(MAX_DLY) ? AW'(MAX_DLY) : io_col.dly_cfg;
    // data is qualified only by the valid bits, so flush/load leave it shifting normally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_DLY; k++) r_data[k] <= '0;
        end else if (io_col.ce) begin
            r_data[0] <= io_col.blk_col_i;
            for (int k = 1; k < MAX_DLY; k++) r_data[k] <= r_data[k-1];
        end
    end
    // a delay change drops everything in flight so no column is duplicated or skipped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld     <= '0;
            r_cur_dly <= AW'(DEF_DLY);
        end else begin
            if (io_col.dly_load) r_cur_dly <= w_dly_clamp;
            if (io_col.flush || io_col.dly_load) r_vld <= '0;
            else if (io_col.ce) r_vld <= w_vld_ext[MAX_DLY-1:0];
        end
    end
    // tap select and drain status only look at the stages inside the active delay
    always_comb begin
        w_col_o   = '0;
        w_vld_o   = 1'b0;
        w_pending = 1'b0;
        for (int k = 0; k < MAX_DLY; k++) begin
            if (r_cur_dly == AW'(k + 1)) begin
                w_col_o = r_data[k];
                w_vld_o = r_vld[k];
            end
            if (AW'(k) < r_cur_dly) w_pending = w_pending | r_vld[k];
        end
    end
    assign io_col.blk_col_o      = w_col_o;
    assign io_col.blk_col_ovalid = io_col.ce & w_vld_o;
    assign io_col.cur_dly        = r_cur_dly;
    assign io_col.pending        = w_pending;
endmodule

// File: tb/tb_blk_col_var_dly.sv
// tb_blk_col_var_dly: directed self-checking bench for blk_col_var_dly
module tb_blk_col_var_dly;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    blk_col_var_dly_if #(.DATA_W(32), .MAX_DLY(8)) bus ();
    blk_col_var_dly #(.DATA_W(32), .MAX_DLY(8), .DEF_DLY(1)) dut (
        .clk(clk),
        .rst(rst),
        .io_col(bus)
    );
    task automatic drive(input logic ce, input logic fl, input logic ld, input logic [3:0] cfg,
                         input logic [31:0] d, input logic v);
        bus.ce = ce;
        bus.flush = fl;
        bus.dly_load = ld;
        bus.dly_cfg = cfg;
        bus.blk_col_i = d;
        bus.blk_col_ivalid = v;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 32'hDEADBEEF, 1'b1);
        @(posedge clk);
        #4;
        total++; if (bus.blk_col_o !== 32'h0) begin bad++; $display("FAIL reset_o got=%h want=%h", bus.blk_col_o, 32'h0); end
        total++; if (bus.blk_col_ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b want=0", bus.blk_col_ovalid); end
        total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b want=0", bus.pending); end
        total++; if (bus.cur_dly !== 4'd1) begin bad++; $display("FAIL reset_cur_dly got=%0d want=1", bus.cur_dly); end
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        tick();
    endtask
    task automatic test_fixed();
        int nv = 0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, i < 16 ? 32'(i + 1) : 32'h0, i < 16);
            #4;
            total++; if (bus.blk_col_ovalid !== (i >= 1 && i <= 16)) begin bad++; $display("FAIL fixed_ovalid cyc=%0d got=%b want=%b", i, bus.blk_col_ovalid, (i >= 1 && i <= 16)); end
            if (i >= 1 && i <= 16) begin
                total++; if (bus.blk_col_o !== 32'(i)) begin bad++; $display("FAIL fixed_data cyc=%0d got=%h want=%h", i, bus.blk_col_o, 32'(i)); end
            end
            if (bus.blk_col_ovalid === 1'b1) nv++;
            tick();
        end
        total++; if (nv != 16) begin bad++; $display("FAIL fixed_count got=%0d want=16", nv); end
    endtask
    task automatic test_runtime_delay();
        logic [3:0] cfgs [4] = '{4'd0, 4'd9, 4'd15, 4'd3};
        logic [3:0] exps [4] = '{4'd1, 4'd8, 4'd8, 4'd3};
        int np = 0;
        drive(1'b1, 1'b0, 1'b1, 4'd5, 32'h0, 1'b0);
        tick();
        total++; if (bus.cur_dly !== 4'd5) begin bad++; $display("FAIL rt_cur_dly got=%0d want=5", bus.cur_dly); end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, i == 0 ? 32'hA5A5A5A5 : 32'h0, i == 0);
            #4;
            total++; if (bus.blk_col_ovalid !== (i == 5)) begin bad++; $display("FAIL rt_ovalid cyc=%0d got=%b want=%b", i, bus.blk_col_ovalid, (i == 5)); end
            if (i == 5) begin
                total++; if (bus.blk_col_o !== 32'hA5A5A5A5) begin bad++; $display("FAIL rt_data got=%h want=a5a5a5a5", bus.blk_col_o); end
            end
            if (bus.blk_col_ovalid === 1'b1) np++;
            tick();
        end
        total++; if (np != 1) begin bad++; $display("FAIL rt_pulses got=%0d want=1", np); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, cfgs[i], 32'h0, 1'b0);
            tick();
            total++; if (bus.cur_dly !== exps[i]) begin bad++; $display("FAIL clamp cfg=%0d got=%0d want=%0d", cfgs[i], bus.cur_dly, exps[i]); end
        end
    endtask
    task automatic test_stall();
        logic st;
        drive(1'b1, 1'b0, 1'b1, 4'd3, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 13; i++) begin
            st = (i >= 3 && i <= 6);
            drive(!st, 1'b0, 1'b0, 4'd0, 32'(i + 1), i < 3);
            #4;
            total++; if (bus.blk_col_ovalid !== (i >= 7 && i <= 9)) begin bad++; $display("FAIL stall_ovalid cyc=%0d got=%b want=%b", i, bus.blk_col_ovalid, (i >= 7 && i <= 9)); end
            if (st) begin
                total++; if (bus.blk_col_o !== 32'd1) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h want=1", i, bus.blk_col_o); end
            end
            if (i >= 7 && i <= 9) begin
                total++; if (bus.blk_col_o !== 32'(i - 6)) begin bad++; $display("FAIL stall_data cyc=%0d got=%h want=%h", i, bus.blk_col_o, 32'(i - 6)); end
            end
            tick();
        end
    endtask
    task automatic test_collision();
        drive(1'b1, 1'b0, 1'b1, 4'd4, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i < 3) drive(1'b1, 1'b0, 1'b0, 4'd0, 32'h11 * 32'(i + 1), 1'b1);
            else if (i == 3) drive(1'b1, 1'b1, 1'b1, 4'd2, 32'h44, 1'b1);
            else drive(1'b1, 1'b0, 1'b0, 4'd0, i == 4 ? 32'h55 : 32'h0, i == 4);
            #4;
            if (i == 3) begin
                total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL coll_pending_before got=%b want=1", bus.pending); end
            end
            if (i == 4) begin
                total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL coll_pending_after got=%b want=0", bus.pending); end
                total++; if (bus.cur_dly !== 4'd2) begin bad++; $display("FAIL coll_cur_dly got=%0d want=2", bus.cur_dly); end
            end
            total++; if (bus.blk_col_ovalid !== (i == 6)) begin bad++; $display("FAIL coll_ovalid cyc=%0d got=%b want=%b", i, bus.blk_col_ovalid, (i == 6)); end
            if (i == 6) begin
                total++; if (bus.blk_col_o !== 32'h55) begin bad++; $display("FAIL coll_data got=%h want=55", bus.blk_col_o); end
            end
            tick();
        end
    endtask
    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b1, 4'd8, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, 32'h60 + 32'(i), 1'b1);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        #2;
        total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL arst_pending_before got=%b want=1", bus.pending); end
        rst = 1'b1;
        #1;
        total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL arst_pending got=%b want=0", bus.pending); end
        total++; if (bus.blk_col_ovalid !== 1'b0) begin bad++; $display("FAIL arst_ovalid got=%b want=0", bus.blk_col_ovalid); end
        total++; if (bus.blk_col_o !== 32'h0) begin bad++; $display("FAIL arst_o got=%h want=0", bus.blk_col_o); end
        total++; if (bus.cur_dly !== 4'd1) begin bad++; $display("FAIL arst_cur_dly got=%0d want=1", bus.cur_dly); end
        #2;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, i == 0 ? 32'h77 : 32'h0, i == 0);
            #4;
            total++; if (bus.blk_col_ovalid !== (i == 1)) begin bad++; $display("FAIL arst_post_ovalid cyc=%0d got=%b want=%b", i, bus.blk_col_ovalid, (i == 1)); end
            if (i == 1) begin
                total++; if (bus.blk_col_o !== 32'h77) begin bad++; $display("FAIL arst_post_data got=%h want=77", bus.blk_col_o); end
            end
            tick();
        end
    endtask
    task automatic test_bubbles();
        logic [4:0] pat = 5'b01101;
        logic ev;
        drive(1'b1, 1'b0, 1'b1, 4'd8, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0, 32'hB0 + 32'(i), i < 5 ? pat[i] : 1'b0);
            #4;
            ev = (i >= 8 && i < 13) ? pat[i - 8] : 1'b0;
            total++; if (bus.blk_col_ovalid !== ev) begin bad++; $display("FAIL bub_ovalid cyc=%0d got=%b want=%b", i, bus.blk_col_ovalid, ev); end
            if (ev) begin
                total++; if (bus.blk_col_o !== 32'hB0 + 32'(i - 8)) begin bad++; $display("FAIL bub_data cyc=%0d got=%h want=%h", i, bus.blk_col_o, 32'hB0 + 32'(i - 8)); end
            end
            tick();
        end
    endtask
    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
    initial begin
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        test_reset();
        test_fixed();
        test_runtime_delay();
        test_stall();
        test_collision();
        test_async_reset();
        test_bubbles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
